// File: rtl/pipelined_alu_unit.sv
// Handshaked ALU: one operation in flight, registered result and flags, shifts and an
// iterative shift-add multiply. The FSM state is exported on dbg_state for checkers.
module pipelined_alu_unit #(
  parameter int WIDTH  = 32,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       sel,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             Cout,
  output logic             Negative,
  output logic             Zero,
  output logic             Overflow,
  output logic             err,
  output logic [1:0]       dbg_state
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);
  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_NOT  = 4'b0010;
  localparam logic [3:0] OP_NOR  = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NAND = 4'b0101;
  localparam logic [3:0] OP_ADD  = 4'b0110;
  localparam logic [3:0] OP_SUB  = 4'b0111;
  localparam logic [3:0] OP_SHL  = 4'b1000;
  localparam logic [3:0] OP_SHR  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_BUSY = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       sel_q, sel_d;
  logic             cin_q, cin_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             res_c_q, res_c_d;
  logic             res_v_q, res_v_d;
  logic             res_err_q, res_err_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             cout_q, cout_d;
  logic             neg_q, neg_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic             out_valid_q, out_valid_d;

  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] alu_y;
  logic             alu_c;
  logic             alu_v;
  logic             alu_err;
  logic             in_is_mul;

  // Handshake: a transfer happens on a rising edge where valid && ready are both high.
  // in_ready is only high in IDLE (and never during reset); out_valid stays high with
  // Y/flags frozen until the edge that sees out_ready, after which the FSM returns to IDLE.
  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign Y         = y_q;
  assign Cout      = cout_q;
  assign Negative  = neg_q;
  assign Zero      = zero_q;
  assign Overflow  = ovf_q;
  assign err       = err_q;
  assign dbg_state = state_q;

  assign in_is_mul = (sel == OP_MUL) && (MUL_EN != 0);

  // Single-cycle datapath operating on the captured operands.
  always_comb begin
    shamt    = b_q[SHW-1:0];
    add_full = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
    sub_full = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
    alu_y    = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    alu_err  = 1'b0;
    case (sel_q)
      OP_AND:  alu_y = a_q & b_q;
      OP_OR:   alu_y = a_q | b_q;
      OP_NOT:  alu_y = ~a_q;
      OP_NOR:  alu_y = ~(a_q | b_q);
      OP_XOR:  alu_y = a_q ^ b_q;
      OP_NAND: alu_y = ~(a_q & b_q);
      OP_ADD: begin
        alu_y = add_full[WIDTH-1:0];
        alu_c = add_full[WIDTH];
        alu_v = (a_q[MSB] == b_q[MSB]) && (add_full[MSB] != a_q[MSB]);
      end
      OP_SUB: begin
        alu_y = sub_full[WIDTH-1:0];
        alu_c = sub_full[WIDTH];
        alu_v = (a_q[MSB] != b_q[MSB]) && (sub_full[MSB] != a_q[MSB]);
      end
      OP_SHL:  alu_y = a_q << shamt;
      OP_SHR:  alu_y = a_q >> shamt;
      OP_SRA:  alu_y = $unsigned($signed(a_q) >>> shamt);
      // MUL only reaches this path when the multiplier is disabled, so it is illegal here.
      default: alu_err = 1'b1;
    endcase
  end

  // One shift-add step: {hi,lo} starts as {0,B} and ends as the full 2*WIDTH product.
  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : {(WIDTH + 1){1'b0}});

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sel_d       = sel_q;
    cin_d       = cin_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    res_d       = res_q;
    res_c_d     = res_c_q;
    res_v_d     = res_v_q;
    res_err_d   = res_err_q;
    y_d         = y_q;
    cout_d      = cout_q;
    neg_d       = neg_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          sel_d   = sel;
          cin_d   = Cin;
          cnt_d   = '0;
          hi_d    = '0;
          lo_d    = B;
          state_d = in_is_mul ? S_BUSY : S_EXEC;
        end
      end
      S_EXEC: begin
        res_d     = alu_y;
        res_c_d   = alu_c;
        res_v_d   = alu_v;
        res_err_d = alu_err;
        state_d   = S_DONE;
      end
      S_BUSY: begin
        if (cnt_q == CW'(WIDTH)) begin
          res_d     = lo_q;
          res_c_d   = |hi_q;
          res_v_d   = 1'b0;
          res_err_d = 1'b0;
          state_d   = S_DONE;
        end else begin
          hi_d  = mul_sum[WIDTH:1];
          lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        // First DONE cycle publishes the staged result; afterwards wait for the consumer.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          y_d         = res_q;
          cout_d      = res_c_q;
          neg_d       = res_q[MSB];
          zero_d      = (res_q == '0);
          ovf_d       = res_v_q;
          err_d       = res_err_q;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sel_q       <= '0;
      cin_q       <= 1'b0;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      res_q       <= '0;
      res_c_q     <= 1'b0;
      res_v_q     <= 1'b0;
      res_err_q   <= 1'b0;
      y_q         <= '0;
      cout_q      <= 1'b0;
      neg_q       <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sel_q       <= sel_d;
      cin_q       <= cin_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      res_q       <= res_d;
      res_c_q     <= res_c_d;
      res_v_q     <= res_v_d;
      res_err_q   <= res_err_d;
      y_q         <= y_d;
      cout_q      <= cout_d;
      neg_q       <= neg_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

  a_no_overlap: assert property (@(posedge clk) !(in_ready && out_valid_q));
  a_valid_in_done: assert property (@(posedge clk) disable iff (rst)
    out_valid_q |-> (state_q == S_DONE));

endmodule

// File: tb/tb_pipelined_alu_unit.sv
// Self-checking bench for pipelined_alu_unit (WIDTH=32, MUL_EN=1): directed spec cases,
// stall/hold, reset abort, illegal opcodes and randomized ops against a reference model.
module tb_pipelined_alu_unit;
  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] y;
    logic         c;
    logic         n;
    logic         z;
    logic         v;
    logic         e;
  } res_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [3:0]   sel = '0;
  logic         Cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] Y;
  logic         Cout, Negative, Zero, Overflow, err;
  logic [1:0]   dbg_state;

  int tests_run = 0;
  int tests_failed = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  pipelined_alu_unit #(.WIDTH(W), .MUL_EN(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .sel(sel), .Cin(Cin), .out_valid(out_valid), .out_ready(out_ready),
    .Y(Y), .Cout(Cout), .Negative(Negative), .Zero(Zero), .Overflow(Overflow),
    .err(err), .dbg_state(dbg_state)
  );

  // Reference model: plain arithmetic on wide/signed integers.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [3:0] op, input logic cin);
    res_t r;
    longint sa, sb, t;
    longint max_s, min_s;
    logic [63:0] p;
    int sh;
    r = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    max_s = 64'sd2147483647;
    min_s = -64'sd2147483648;
    sh = int'(b[4:0]);
    case (op)
      4'd0: r.y = a & b;
      4'd1: r.y = a | b;
      4'd2: r.y = ~a;
      4'd3: r.y = ~(a | b);
      4'd4: r.y = a ^ b;
      4'd5: r.y = ~(a & b);
      4'd6: begin
        p = 64'(a) + 64'(b) + 64'(cin);
        r.y = p[W-1:0];
        r.c = p[W];
        t = sa + sb + longint'(cin);
        r.v = (t > max_s) || (t < min_s);
      end
      4'd7: begin
        r.y = a - b;
        r.c = (a >= b);
        t = sa - sb;
        r.v = (t > max_s) || (t < min_s);
      end
      4'd8: begin p = 64'(a) * (64'd1 << sh); r.y = p[W-1:0]; end
      4'd9: begin p = 64'(a) / (64'd1 << sh); r.y = p[W-1:0]; end
      4'd10: begin t = sa >>> sh; r.y = t[W-1:0]; end
      4'd11: begin
        p = 64'(a) * 64'(b);
        r.y = p[W-1:0];
        r.c = |p[63:W];
      end
      default: r.e = 1'b1;
    endcase
    r.n = r.y[W-1];
    r.z = (r.y == '0);
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic scramble_inputs();
    A = $urandom;
    B = $urandom;
    sel = 4'($urandom_range(0, 15));
    Cin = 1'($urandom_range(0, 1));
  endtask

  task automatic send_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                         input logic [3:0] op_sel, input logic op_cin, output bit ok);
    int waited;
    res_t m;
    waited = 0;
    ok = 1'b0;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (in_ready) begin
      A = op_a; B = op_b; sel = op_sel; Cin = op_cin;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      scramble_inputs();
      m = model(op_a, op_b, op_sel, op_cin);
      exp_q.push_back(m.y);
      ok = 1'b1;
    end
  endtask

  task automatic wait_result(output res_t r, output int lat, output bit rdy_seen);
    lat = 0;
    rdy_seen = 1'b0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (in_ready) rdy_seen = 1'b1;
    end while (!out_valid && lat < 100);
    r = {Y, Cout, Negative, Zero, Overflow, err};
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready_after got %b want 1", in_ready); end
    tests_run++;
    if ({Y, Cout, Negative, Zero, Overflow, err} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs got Y=%h flags=%b want 0", Y, {Cout, Negative, Zero, Overflow, err});
    end
    tests_run++;
    if (dbg_state !== 2'd0) begin tests_failed++; $display("FAIL reset_state got %0d want 0", dbg_state); end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta[8], tb_[8], ty[8];
    logic [3:0]   ts[8];
    logic         tc[8];
    logic [4:0]   tf[8];
    int           tl[8];
    res_t r, m;
    int lat;
    bit rdy, ok;
    logic [W-1:0] e;
    ta = '{32'h7FFFFFFF, 32'd5, 32'd0, 32'h00010000, 32'd7, 32'd1, 32'h80000000, 32'hF0F0F0F0};
    tb_ = '{32'd1, 32'd5, 32'd1, 32'h00010003, 32'd6, 32'd31, 32'd0, 32'hFF00FF00};
    ts = '{4'b0110, 4'b0111, 4'b0111, 4'b1011, 4'b1011, 4'b1000, 4'b1001, 4'b0000};
    tc = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    ty = '{32'h80000000, 32'h0, 32'hFFFFFFFF, 32'h00030000, 32'd42, 32'h80000000,
           32'h80000000, 32'hF000F000};
    tf = '{5'b01010, 5'b10100, 5'b01000, 5'b10000, 5'b00000, 5'b01000, 5'b01000, 5'b01000};
    tl = '{2, 2, 2, 34, 34, 2, 2, 2};
    for (int i = 0; i < 8; i++) begin
      send_op(ta[i], tb_[i], ts[i], tc[i], ok);
      tests_run++;
      if (ok !== 1'b1) begin tests_failed++; $display("FAIL dir%0d_accept got %b want 1", i, ok); end
      wait_result(r, lat, rdy);
      m = model(ta[i], tb_[i], ts[i], tc[i]);
      tests_run++;
      if (lat !== tl[i]) begin tests_failed++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, tl[i]); end
      tests_run++;
      if (rdy !== 1'b0) begin tests_failed++; $display("FAIL dir%0d_busy_ready got %b want 0", i, rdy); end
      tests_run++;
      if (r !== {ty[i], tf[i]}) begin
        tests_failed++;
        $display("FAIL dir%0d_result got Y=%h f=%b want Y=%h f=%b", i, r.y, r[4:0], ty[i], tf[i]);
      end
      tests_run++;
      if (r !== m) begin tests_failed++; $display("FAIL dir%0d_model got %h want %h", i, r, m); end
      release_result();
      tests_run++;
      if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL dir%0d_drop got %b want 0", i, out_valid); end
      e = exp_q.pop_front();
      tests_run++;
      if (r.y !== e) begin tests_failed++; $display("FAIL dir%0d_scoreboard got %h want %h", i, r.y, e); end
    end
  endtask

  task automatic test_hold();
    res_t r, m;
    int lat;
    bit rdy, ok, seen;
    logic [W-1:0] e;
    logic [3:0] ops[2];
    logic [W-1:0] ey[2];
    ops = '{4'b1010, 4'b1001};
    ey = '{32'hF8000000, 32'h08000000};
    for (int k = 0; k < 2; k++) begin
      send_op(32'h80000000, 32'd4, ops[k], 1'b0, ok);
      wait_result(r, lat, rdy);
      m = model(32'h80000000, 32'd4, ops[k], 1'b0);
      tests_run++;
      if (r.y !== ey[k]) begin tests_failed++; $display("FAIL hold%0d_y got %h want %h", k, r.y, ey[k]); end
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        in_valid = 1'b1;
        scramble_inputs();
        @(posedge clk);
        #1;
        tests_run++;
        if ({out_valid, in_ready} !== 2'b10) begin
          tests_failed++;
          $display("FAIL hold%0d_hs c%0d got v=%b r=%b want v=1 r=0", k, c, out_valid, in_ready);
        end
        tests_run++;
        if ({Y, Cout, Negative, Zero, Overflow, err} !== m) begin
          tests_failed++;
          $display("FAIL hold%0d_stable c%0d got %h want %h", k, c, {Y, Cout, Negative, Zero, Overflow, err}, m);
        end
      end
      @(negedge clk);
      in_valid = 1'b0;
      release_result();
      seen = 1'b0;
      repeat (4) begin
        @(posedge clk);
        #1;
        if (out_valid) seen = 1'b1;
      end
      tests_run++;
      if (seen !== 1'b0) begin tests_failed++; $display("FAIL hold%0d_ghost_op got %b want 0", k, seen); end
      e = exp_q.pop_front();
      tests_run++;
      if (r.y !== e) begin tests_failed++; $display("FAIL hold%0d_scoreboard got %h want %h", k, r.y, e); end
    end
  endtask

  task automatic test_reset_mid_mul();
    res_t r;
    int lat;
    bit rdy, ok, seen;
    logic [W-1:0] e;
    send_op($urandom, $urandom, 4'b1011, 1'b0, ok);
    void'(exp_q.pop_back());
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL abort_ready got %b want 1", in_ready); end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin tests_failed++; $display("FAIL abort_no_result got %b want 0", seen); end
    send_op(32'hF0F0F0F0, 32'hFF00FF00, 4'b0000, 1'b0, ok);
    wait_result(r, lat, rdy);
    tests_run++;
    if (r !== {32'hF000F000, 5'b01000}) begin
      tests_failed++;
      $display("FAIL abort_follow_and got %h want %h", r, {32'hF000F000, 5'b01000});
    end
    tests_run++;
    if (lat !== 2) begin tests_failed++; $display("FAIL abort_follow_latency got %0d want 2", lat); end
    release_result();
    e = exp_q.pop_front();
    tests_run++;
    if (r.y !== e) begin tests_failed++; $display("FAIL abort_scoreboard got %h want %h", r.y, e); end
  endtask

  task automatic test_illegal();
    res_t r;
    int lat;
    bit rdy, ok;
    for (int op = 12; op < 16; op++) begin
      send_op(32'hFFFFFFFF, 32'hFFFFFFFF, 4'(op), 1'($urandom_range(0, 1)), ok);
      wait_result(r, lat, rdy);
      tests_run++;
      if (r !== {32'h0, 5'b00101}) begin
        tests_failed++;
        $display("FAIL illegal_%0d got Y=%h f=%b want Y=0 f=00101", op, r.y, r[4:0]);
      end
      release_result();
      void'(exp_q.pop_front());
    end
    send_op(32'h12345678, 32'h12345678, 4'b0100, 1'b0, ok);
    wait_result(r, lat, rdy);
    tests_run++;
    if (r !== {32'h0, 5'b00100}) begin
      tests_failed++;
      $display("FAIL illegal_err_clear got Y=%h f=%b want Y=0 f=00100", r.y, r[4:0]);
    end
    release_result();
    void'(exp_q.pop_front());
  endtask

  task automatic test_random();
    res_t r, m;
    int lat, want_lat;
    bit rdy, ok;
    logic [W-1:0] a, b, e;
    logic [W-1:0] corners[4];
    logic [3:0] op;
    logic cin;
    corners = '{32'h0, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    for (int i = 0; i < 150; i++) begin
      a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
      op = 4'($urandom_range(0, 15));
      cin = 1'($urandom_range(0, 1));
      send_op(a, b, op, cin, ok);
      wait_result(r, lat, rdy);
      m = model(a, b, op, cin);
      want_lat = (op == 4'b1011) ? 34 : 2;
      tests_run++;
      if (lat !== want_lat) begin tests_failed++; $display("FAIL rnd%0d_latency op=%h got %0d want %0d", i, op, lat, want_lat); end
      tests_run++;
      if (r !== m) begin
        tests_failed++;
        $display("FAIL rnd%0d_result op=%h a=%h b=%h cin=%b got %h want %h", i, op, a, b, cin, r, m);
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      release_result();
      e = exp_q.pop_front();
      tests_run++;
      if (r.y !== e) begin tests_failed++; $display("FAIL rnd%0d_scoreboard got %h want %h", i, r.y, e); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_reset_mid_mul();
    test_illegal();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
